// File: rtl/mem_responder.sv
// Single-port word memory answering a held read/write request with a one-cycle mem_resp pulse LATENCY cycles after acceptance.
// No queue: one transaction at a time, protocol violations abort the transaction and set sticky proto_err.
module mem_responder #(
    parameter int LATENCY     = 3,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        proto_err
);
    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 2);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic             is_write_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic [31:0]      mem_rdata_q;
    logic             mem_resp_q;
    logic             proto_err_q;
    logic [31:0]      mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0] addr_idx;
    logic             unused_addr;
    logic             req_one;
    logic             req_both;
    logic             abort;
    logic             enter_resp;
    logic             wr_now;
    logic [IDX_W-1:0] idx_now;
    logic [31:0]      wdata_now;
    logic [3:0]       be_now;
    logic             commit_wr;

    assign addr_idx    = mem_address[IDX_W+1:2];
    assign unused_addr = ^{mem_address[31:IDX_W+2], mem_address[1:0]};

    always_comb begin
        req_one    = mem_read ^ mem_write;
        req_both   = mem_read & mem_write;
        abort      = 1'b0;
        if (state_q == BUSY) begin
            abort = is_write_q ? (!mem_write || mem_read) : (!mem_read || mem_write);
        end
        enter_resp = ((state_q == IDLE) && req_one && (LATENCY == 1)) ||
                     ((state_q == BUSY) && !abort && (cnt_q == LAST_CNT));
        // With LATENCY=1 the commit happens on the acceptance edge, so live inputs stand in for the latches
        if (state_q == IDLE) begin
            wr_now    = mem_write;
            idx_now   = addr_idx;
            wdata_now = mem_wdata;
            be_now    = mem_byte_enable;
        end else begin
            wr_now    = is_write_q;
            idx_now   = idx_q;
            wdata_now = wdata_q;
            be_now    = be_q;
        end
        commit_wr  = rst && enter_resp && wr_now;
    end

    always_ff @(posedge clk) begin
        if (commit_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be_now[i]) begin
                    mem_q[idx_now][8*i +: 8] <= wdata_now[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            mem_resp_q  <= 1'b0;
            mem_rdata_q <= 32'h0;
            proto_err_q <= 1'b0;
        end else begin
            mem_resp_q <= enter_resp;
            if (enter_resp && !wr_now) begin
                mem_rdata_q <= mem_q[idx_now];
            end
            case (state_q)
                IDLE: begin
                    if (req_both) begin
                        proto_err_q <= 1'b1;
                    end else if (req_one) begin
                        is_write_q <= mem_write;
                        idx_q      <= addr_idx;
                        wdata_q    <= mem_wdata;
                        be_q       <= mem_byte_enable;
                        cnt_q      <= 4'd0;
                        state_q    <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    if (abort) begin
                        state_q     <= IDLE;
                        proto_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= RESP;
                        end
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_rdata = mem_rdata_q;
    assign mem_resp  = mem_resp_q;
    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=3 instance for function, LATENCY=1 instance for back-to-back timing.
module tb_mem_responder;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr, rd1;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, rdata1;
    logic        resp, resp1, perr, perr1;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(3), .DEPTH_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .mem_read(rd), .mem_write(wr),
        .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata),
        .mem_rdata(rdata), .mem_resp(resp), .proto_err(perr)
    );

    mem_responder #(.LATENCY(1), .DEPTH_WORDS(1024)) dut1 (
        .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(1'b0),
        .mem_byte_enable(4'h0), .mem_address(32'h0), .mem_wdata(32'h0),
        .mem_rdata(rdata1), .mem_resp(resp1), .proto_err(perr1)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; rd = 1'b0; wr = 1'b0; rd1 = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Drive one request, wait for its response and score it against the queued expectation
    task automatic txn(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] exp_rd, input bit scramble);
        exp_t e;
        int   cyc;
        e.is_rd = !is_wr;
        e.data  = exp_rd;
        sb.push_back(e);
        addr = a; wdata = d; be = b; wr = is_wr; rd = !is_wr;
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (scramble && c == 1) begin
                addr  = $urandom;
                wdata = $urandom;
                be    = 4'($urandom);
            end
            if (resp) begin
                cyc = c;
                break;
            end
        end
        rd = 1'b0; wr = 1'b0;
        chk("resp_latency", cyc, LAT);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (cyc != 0 && e.is_rd) chk("rdata", rdata, e.data);
        end
        if (cyc != 0) begin
            step();
            chk("resp_pulse", resp, 0);
        end
    endtask

    logic [7:0] seen;
    logic       any;

    initial begin
        addr = 32'h0; wdata = 32'h0; be = 4'h0;
        rst = 1'b0; rd = 1'b0; wr = 1'b0; rd1 = 1'b0;
        do_reset();
        chk("rst_resp", resp, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_perr", perr, 0);
        chk("rst_resp_l1", resp1, 0);

        txn(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        txn(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        txn(1'b1, 32'h80, 32'h11223344, 4'hF, 32'h0, 1'b0);
        txn(1'b1, 32'h80, 32'hAABBCCDD, 4'b0100, 32'h0, 1'b0);
        txn(1'b0, 32'h82, 32'h0, 4'h0, 32'h11BB3344, 1'b0);

        txn(1'b1, 32'h1000, 32'h5, 4'hF, 32'h0, 1'b0);
        txn(1'b0, 32'h0, 32'h0, 4'h0, 32'h5, 1'b0);

        txn(1'b1, 32'h40, 32'hCAFEF00D, 4'h0, 32'h0, 1'b0);
        chk("rdata_hold", rdata, 32'h5);
        txn(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        txn(1'b1, 32'hC0, 32'h12345678, 4'hF, 32'h0, 1'b1);
        txn(1'b0, 32'hC0, 32'h0, 4'h0, 32'h12345678, 1'b1);

        seen = 8'h0; addr = 32'h40; rd = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            seen[c] = resp;
            if (c == 7) rd = 1'b0;
        end
        chk("b2b_l3", seen, 8'b1000_1000);
        chk("b2b_rdata", rdata, 32'hDEADBEEF);
        step();
        seen = 8'h0; rd1 = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            seen[c] = resp1;
            if (c == 3) rd1 = 1'b0;
        end
        chk("b2b_l1", seen, 8'b0000_1010);
        step();
        chk("perr_clean", perr, 0);

        addr = 32'h40; wdata = 32'h99; be = 4'hF; wr = 1'b1;
        step();
        wr = 1'b0;
        any = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            any |= resp;
        end
        chk("abort_no_resp", any, 0);
        chk("abort_perr", perr, 1);
        txn(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        chk("perr_sticky", perr, 1);

        do_reset();
        chk("perr_cleared", perr, 0);
        addr = 32'h40; rd = 1'b1; wr = 1'b1;
        any = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            any |= resp;
        end
        rd = 1'b0; wr = 1'b0;
        chk("both_no_resp", any, 0);
        chk("both_perr", perr, 1);

        do_reset();
        txn(1'b1, 32'h10, 32'h77, 4'hF, 32'h0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 32'h77, 1'b0);
        addr = 32'h10; wdata = 32'hFFFFFFFF; be = 4'hF; wr = 1'b1;
        step();
        rst = 1'b0; wr = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_rdata", rdata, 0);
        chk("midrst_perr", perr, 0);
        any = resp;
        for (int c = 0; c < 5; c++) begin
            step();
            any |= resp;
        end
        chk("midrst_no_resp", any, 0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 32'h77, 1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
